if_id_buffer: RTL and testbench

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/if_id_buffer_pkg.sv | 17 +
 rtl/if_id_buffer_imm_gen.sv | 35 +++
 rtl/if_id_buffer.sv | 101 ++++++++++
 tb/tb_if_id_buffer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/if_id_buffer_pkg.sv
// Shared constants for the fetch/decode boundary: opcode encodings and the NOP word.
// Latency: n/a (constants only).
// Backpressure: n/a.
package if_id_buffer_pkg;

    // Major opcodes, instr[6:0], that carry an immediate the decode stage needs.
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // addi x0, x0, 0. Presented to decode whenever the buffer has nothing valid.
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Number of entries held between fetch and decode.
    localparam int unsigned DEPTH = 2;

endpackage

// File: rtl/if_id_buffer_imm_gen.sv
// Immediate extraction for the decode head: I-type (OP-IMM, LOAD) and B-type (BRANCH).
// Latency: purely combinational.
// Backpressure: none, no state.
// Ports: instr  - 32-bit instruction word
//        imm    - sign-extended immediate, zero for opcodes without a supported immediate
module imm_gen
    import if_id_buffer_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic [31:0]              instr,
    output logic [ADDRESS_WIDTH-1:0] imm
);

    logic [11:0] imm_i;
    logic [12:0] imm_b;
    logic [7:0]  unused_bits;

    assign imm_i = instr[31:20];
    // Branch offsets are halfword-aligned, so bit 0 is always zero.
    assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

    // instr[19:12] (rs1 and funct3) never feed an immediate.
    assign unused_bits = instr[19:12];

    always_comb begin
        imm = '0;
        case (instr[6:0])
            OP_IMM, OP_LOAD: imm = {{(ADDRESS_WIDTH-12){imm_i[11]}}, imm_i};
            OP_BRANCH:       imm = {{(ADDRESS_WIDTH-13){imm_b[12]}}, imm_b};
            default:         imm = '0;
        endcase
    end

endmodule

// File: rtl/if_id_buffer.sv
// Two-entry FIFO between instruction fetch and decode, with flush and immediate extraction.
// Latency: 1 cycle from push to head (no bypass); flush empties the buffer on the next edge.
// Backpressure: in_ready = (occupancy < 2) from registered state only; fetch holds data when low.
// Ports: clk/rst (async active-low)        - clock and reset
//        in_valid/in_instr/in_pc/in_ready - push side from fetch
//        flush                            - discard all entries; wins over same-cycle push/pop
//        out_valid/out_instr/out_pc/out_imm/out_ready - head entry to decode
//        occupancy                        - number of valid entries, 0..2
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_instr,
    input  logic [ADDRESS_WIDTH-1:0] in_pc,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_instr,
    output logic [ADDRESS_WIDTH-1:0] out_pc,
    output logic [ADDRESS_WIDTH-1:0] out_imm,
    input  logic                     out_ready,
    output logic [1:0]               occupancy
);

    logic [ADDRESS_WIDTH-1:0] pc_q    [DEPTH];
    logic [DATA_WIDTH-1:0]    instr_q [DEPTH];
    logic                     wr_ptr;
    logic                     rd_ptr;
    logic [1:0]               count;

    logic                     push;
    logic                     pop;
    logic [DATA_WIDTH-1:0]    head_instr;
    logic [ADDRESS_WIDTH-1:0] head_imm;

    // Both handshakes are decided from count alone, so out_ready never reaches in_ready.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign occupancy = count;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q[0]    <= '0;
            pc_q[1]    <= '0;
            instr_q[0] <= '0;
            instr_q[1] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
        end else if (flush) begin
            // Any push arriving with the flush belongs to the squashed path and is dropped.
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                pc_q[wr_ptr]    <= in_pc;
                instr_q[wr_ptr] <= in_instr;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_instr = instr_q[rd_ptr];

    imm_gen #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_imm_gen (
        .instr (head_instr[31:0]),
        .imm   (head_imm)
    );

    // Stale storage is never exposed: an empty buffer looks like a NOP at pc 0.
    always_comb begin
        out_instr = DATA_WIDTH'(NOP);
        out_pc    = '0;
        out_imm   = '0;
        if (out_valid) begin
            out_instr = head_instr;
            out_pc    = pc_q[rd_ptr];
            out_imm   = head_imm;
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic        out_ready;
    logic [1:0]  occupancy;

    int   tests_run;
    int   tests_failed;
    ent_t exp_q[$];

    if_id_buffer #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_imm   (out_imm),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference immediate decode, straight from the instruction formats.
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        logic [12:0] b;
        case (i[6:0])
            7'b0010011, 7'b0000011: ref_imm = {{20{i[31]}}, i[31:20]};
            7'b1100011: begin
                b = {i[31], i[7], i[30:25], i[11:8], 1'b0};
                ref_imm = {{19{b[12]}}, b};
            end
            default: ref_imm = 32'h0;
        endcase
    endfunction

    // Compare every DUT output against the scoreboard head.
    task automatic check_all(input string tag);
        logic        v;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_imm;
        v       = (exp_q.size() != 0);
        e_instr = v ? exp_q[0].instr : 32'h0000_0013;
        e_pc    = v ? exp_q[0].pc : 32'h0;
        e_imm   = v ? ref_imm(exp_q[0].instr) : 32'h0;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".occupancy"}, 32'(occupancy), 32'(exp_q.size()));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(exp_q.size() < 2));
        chk({tag, ".out_instr"}, out_instr, e_instr);
        chk({tag, ".out_pc"},    out_pc,    e_pc);
        chk({tag, ".out_imm"},   out_imm,   e_imm);
    endtask

    // Called at a falling edge: check current outputs, drive one cycle of stimulus,
    // advance the scoreboard to the state expected after the next rising edge.
    task automatic step(input string tag, input logic v, input logic [31:0] ins,
                        input logic [31:0] pcv, input logic r, input logic f);
        logic do_push;
        logic do_pop;
        check_all(tag);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pcv;
        out_ready = r;
        flush     = f;
        do_push = v && (exp_q.size() < 2);
        do_pop  = r && (exp_q.size() != 0);
        if (f) begin
            exp_q.delete();
        end else begin
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back('{instr: ins, pc: pcv});
        end
        @(negedge clk);
    endtask

    logic [6:0] opcodes [5];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        opcodes[0] = 7'b0010011;
        opcodes[1] = 7'b0000011;
        opcodes[2] = 7'b1100011;
        opcodes[3] = 7'b0110011;
        opcodes[4] = 7'b0110111;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_pc     = 32'h0;
        out_ready = 1'b0;
        flush     = 1'b0;
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b1;

        // Single push becomes visible one cycle later.
        step("push1", 1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b0);
        chk("push1.imm_is_5", out_imm, 32'h5);
        step("pop1", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step("pop_empty", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Fill, then a third in_valid must be ignored.
        step("fill_a", 1'b1, 32'hFFF0_0093, 32'h4, 1'b0, 1'b0);
        step("fill_b", 1'b1, 32'h0000_0013, 32'h8, 1'b0, 1'b0);
        chk("full.in_ready", 32'(in_ready), 32'h0);
        chk("full.imm_neg1", out_imm, 32'hFFFF_FFFF);
        step("full_ign", 1'b1, 32'hDEAD_BEEF, 32'hC, 1'b0, 1'b0);

        // Flush with a concurrent push drops everything.
        step("flush", 1'b1, 32'h1234_5013, 32'h10, 1'b1, 1'b1);
        chk("flush.out_instr", out_instr, 32'h0000_0013);
        chk("flush.in_ready", 32'(in_ready), 32'h1);

        // Simultaneous push/pop at occupancy 1 keeps order.
        step("sp_a", 1'b1, 32'h0010_0113, 32'h20, 1'b0, 1'b0);
        step("sp_b", 1'b1, 32'h0020_0193, 32'h24, 1'b1, 1'b0);
        chk("sp.head_pc", out_pc, 32'h24);
        step("sp_c", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Branch immediate, then an R-type head.
        step("br_push", 1'b1, 32'hFE00_0EE3, 32'h30, 1'b0, 1'b0);
        chk("br.imm", out_imm, 32'hFFFF_FFFC);
        step("rt_push", 1'b1, 32'h0020_81B3, 32'h34, 1'b1, 1'b0);
        chk("rt.imm", out_imm, 32'h0);
        step("rt_pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Random traffic with occasional flushes.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] w;
            w = $urandom;
            w[6:0] = opcodes[$urandom_range(0, 4)];
            step("rand", 1'($urandom_range(0, 1)), w, 32'($urandom) & 32'hFFFF_FFFC,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
        end

        // Asynchronous reset between edges with two entries held.
        step("pre_rst_flush", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step("pre_rst_a", 1'b1, 32'h0030_0213, 32'h40, 1'b0, 1'b0);
        step("pre_rst_b", 1'b1, 32'h0040_0293, 32'h44, 1'b0, 1'b0);
        chk("pre_rst.occupancy", 32'(occupancy), 32'h2);
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst.out_valid", 32'(out_valid), 32'h0);
        chk("async_rst.occupancy", 32'(occupancy), 32'h0);
        chk("async_rst.out_instr", out_instr, 32'h0000_0013);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        step("post_rst", 1'b1, 32'h0070_0313, 32'h50, 1'b0, 1'b0);
        step("post_rst2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_all("final");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
